// File: rtl/dma_stream_s2mm.sv
// Stream-to-memory DMA engine: accepts AXI-Stream beats and writes
// them word-by-word into BRAM through the arbiter write channel.

module dma_s2mm_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] rdata
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  assign full  = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module dma_stream_s2mm #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic              err_early_last,
  output logic              err_missing_last,
  output logic [LEN_W-1:0]  words_written,
  input  logic              ss_tvalid,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast,
  output logic              ss_tready,
  output logic              dma_w_valid,
  output logic [ADDR_W-1:0] dma_w_addr,
  output logic [DATA_W-1:0] dma_w_data,
  input  logic              dma_w_ack
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  recv_cnt;
  logic [LEN_W-1:0]  recv_nxt;
  logic [LEN_W-1:0]  ww_q;
  logic              early_q;
  logic              miss_q;
  logic              done_q;

  logic              start_ok;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              last_beat;
  logic              early_beat;

  // busy also covers the registered done cycle after FIN
  assign busy     = (state != IDLE) || done_q;
  assign start_ok = cfg_start && !busy;

  assign ss_tready  = (state == RUN) && !fifo_full;
  assign push       = ss_tvalid && ss_tready;
  assign recv_nxt   = recv_cnt + LEN_W'(1);
  assign last_beat  = push && (recv_nxt == len_q);
  assign early_beat = push && ss_tlast && !last_beat;

  assign dma_w_valid = !fifo_empty;
  assign pop         = dma_w_valid && dma_w_ack;
  assign dma_w_addr  = base_q + ADDR_W'(ww_q);
  assign dma_w_data  = dma_w_valid ? fifo_head : '0;

  assign done             = done_q;
  assign err_early_last   = early_q;
  assign err_missing_last = miss_q;
  assign words_written    = ww_q;

  dma_s2mm_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .wdata (ss_tdata),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (fifo_head)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = (cfg_len != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (last_beat || early_beat) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      base_q   <= '0;
      len_q    <= '0;
      recv_cnt <= '0;
      ww_q     <= '0;
      early_q  <= 1'b0;
      miss_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == FIN);
      if (start_ok) begin
        base_q   <= cfg_base_addr;
        len_q    <= cfg_len;
        recv_cnt <= '0;
        ww_q     <= '0;
        early_q  <= 1'b0;
        miss_q   <= 1'b0;
      end
      if (push) begin
        recv_cnt <= recv_nxt;
        if (early_beat) begin
          early_q <= 1'b1;
        end
        if (last_beat && !ss_tlast) begin
          miss_q <= 1'b1;
        end
      end
      if (pop) begin
        ww_q <= ww_q + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dma_stream_s2mm.sv
// Scoreboard bench for dma_stream_s2mm: accepted beats are queued
// with their expected BRAM address and checked as writes are acked.

module tb_dma_stream_s2mm;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 11;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              busy;
  logic              done;
  logic              err_early_last;
  logic              err_missing_last;
  logic [LEN_W-1:0]  words_written;
  logic              ss_tvalid = 1'b0;
  logic [DATA_W-1:0] ss_tdata = '0;
  logic              ss_tlast = 1'b0;
  logic              ss_tready;
  logic              dma_w_valid;
  logic [ADDR_W-1:0] dma_w_addr;
  logic [DATA_W-1:0] dma_w_data;
  logic              dma_w_ack = 1'b0;

  always #5 clk = ~clk;

  dma_stream_s2mm #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst),
    .cfg_start        (cfg_start),
    .cfg_base_addr    (cfg_base_addr),
    .cfg_len          (cfg_len),
    .busy             (busy),
    .done             (done),
    .err_early_last   (err_early_last),
    .err_missing_last (err_missing_last),
    .words_written    (words_written),
    .ss_tvalid        (ss_tvalid),
    .ss_tdata         (ss_tdata),
    .ss_tlast         (ss_tlast),
    .ss_tready        (ss_tready),
    .dma_w_valid      (dma_w_valid),
    .dma_w_addr       (dma_w_addr),
    .dma_w_data       (dma_w_data),
    .dma_w_ack        (dma_w_ack)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t sb[$];

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  bit tready_seen = 0;
  logic [ADDR_W-1:0] cur_base = '0;
  logic              stall_q = 1'b0;
  logic [ADDR_W-1:0] stall_addr = '0;
  logic [DATA_W-1:0] stall_data = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    #1;
    cyc++;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (cfg_start && !busy) start_cyc = cyc;
      if (ss_tready) tready_seen = 1;
      if (stall_q) begin
        chk("stall_hold", 64'({dma_w_valid, dma_w_addr, dma_w_data}),
            64'({1'b1, stall_addr, stall_data}));
      end
      if (ss_tvalid && ss_tready) begin
        chk("fifo_room", 64'((acc_cnt - wr_cnt) < DEPTH), 64'd1);
        e.addr = cur_base + ADDR_W'(acc_cnt);
        e.data = ss_tdata;
        sb.push_back(e);
        acc_cnt++;
      end
      if (dma_w_valid && dma_w_ack) begin
        if (sb.size() == 0) begin
          chk("write_unexpected", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("w_addr", 64'(dma_w_addr), 64'(e.addr));
          chk("w_data", 64'(dma_w_data), 64'(e.data));
        end
        wr_cnt++;
      end
      stall_q    = dma_w_valid && !dma_w_ack;
      stall_addr = dma_w_addr;
      stall_data = dma_w_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic start_burst(input logic [ADDR_W-1:0] base,
                             input logic [LEN_W-1:0] len);
    acc_cnt     = 0;
    wr_cnt      = 0;
    done_cnt    = 0;
    tready_seen = 0;
    cur_base    = base;
    sb.delete();
    @(negedge clk);
    cfg_start     = 1'b1;
    cfg_base_addr = base;
    cfg_len       = len;
    ss_tvalid     = 1'b0;
    dma_w_ack     = 1'b0;
  endtask

  // mode 0: ack always high; mode 1: ack low 10 cycles after first write
  task automatic drive_cycle(input int nbeats, input int last_idx,
                             input int mode, input bit poke,
                             inout int hold);
    @(negedge clk);
    cfg_start = poke;
    if (poke) begin
      cfg_base_addr = 13'h0;
      cfg_len       = 11'd1;
    end
    if (acc_cnt < nbeats) begin
      ss_tvalid = 1'b1;
      ss_tdata  = 32'hA0 + 32'(acc_cnt);
      ss_tlast  = (acc_cnt == last_idx);
    end else begin
      ss_tvalid = 1'b0;
      ss_tlast  = 1'b0;
    end
    dma_w_ack = 1'b1;
    if (mode == 1 && wr_cnt >= 1 && hold < 10) begin
      dma_w_ack = 1'b0;
      hold++;
    end
  endtask

  task automatic run_burst(input string tag,
                           input logic [ADDR_W-1:0] base,
                           input logic [LEN_W-1:0] len,
                           input int nbeats, input int last_idx,
                           input int mode, input int exp_w,
                           input bit exp_early, input bit exp_miss);
    int hold;
    hold = 0;
    start_burst(base, len);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      drive_cycle(nbeats, last_idx, mode, (mode == 1 && i == 3), hold);
    end
    chk({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
    drive_cycle(nbeats, last_idx, mode, 1'b0, hold);
    #2;
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    chk({tag, "_tready_off"}, 64'(ss_tready), 64'd0);
    drive_cycle(nbeats, last_idx, mode, 1'b0, hold);
    #2;
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, "_writes"}, 64'(wr_cnt), 64'(exp_w));
    chk({tag, "_accepted"}, 64'(acc_cnt), 64'(exp_w));
    chk({tag, "_words_written"}, 64'(words_written), 64'(exp_w));
    chk({tag, "_err_early"}, 64'(err_early_last), 64'(exp_early));
    chk({tag, "_err_miss"}, 64'(err_missing_last), 64'(exp_miss));
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    ss_tvalid = 1'b0;
    dma_w_ack = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_valid"}, 64'(dma_w_valid), 64'd0);
    chk({tag, "_tready"}, 64'(ss_tready), 64'd0);
    chk({tag, "_ww"}, 64'(words_written), 64'd0);
    chk({tag, "_addr"}, 64'(dma_w_addr), 64'd0);
    chk({tag, "_data"}, 64'(dma_w_data), 64'd0);
    chk({tag, "_errs"}, 64'({err_early_last, err_missing_last}), 64'd0);
  endtask

  initial begin
    int hold;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk_idle("reset");

    run_burst("basic", 13'h0100, 11'd4, 4, 3, 0, 4, 1'b0, 1'b0);
    run_burst("bp", 13'h0040, 11'd8, 8, 7, 1, 8, 1'b0, 1'b0);
    run_burst("early", 13'h0200, 11'd6, 6, 2, 0, 3, 1'b1, 1'b0);
    run_burst("wrap", 13'h1FFE, 11'd4, 4, -1, 0, 4, 1'b0, 1'b1);
    run_burst("len0", 13'h0500, 11'd0, 4, 3, 0, 0, 1'b0, 1'b0);
    chk("len0_latency", 64'(done_cyc - start_cyc), 64'd2);
    chk("len0_no_tready", 64'(tready_seen), 64'd0);

    hold = 0;
    start_burst(13'h0300, 11'd5);
    for (int i = 0; i < 100 && wr_cnt < 2; i++) begin
      drive_cycle(5, 4, 0, 1'b0, hold);
    end
    chk("rst_two_writes", 64'(wr_cnt), 64'd2);
    @(negedge clk);
    rst       = 1'b1;
    ss_tvalid = 1'b0;
    dma_w_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    done_cnt = 0;
    #2;
    chk_idle("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);

    run_burst("post_rst", 13'h0600, 11'd2, 2, 1, 0, 2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_stream_s2mm.md
Name: dma_stream_s2mm

Overview:
- DMA stream-to-memory engine: the receiving end of the accelerator's output AXI-Stream.
- Accepts result beats from the accelerator (ss_* side of the DMA) and writes them word-by-word into BRAM through the arbiter's DMA write channel.
- Burst is started by the DMA register block with a base address and a length.
- A small internal FIFO decouples stream acceptance from arbiter write stalls.

Parameters:
- ADDR_W, 13, BRAM word-address width (matches arbiter dma_w_addr).
- DATA_W, 32, stream and BRAM data width.
- LEN_W, 11, burst length counter width (max 2047 words).
- FIFO_DEPTH, 4, internal buffer depth in words (power of two, >=2).

Ports:
- wb_clk_i  in  1  system clock, all logic rising-edge.
- wb_rst_i  in  1  synchronous reset, active-high.
- cfg_start  in  1  one-cycle start pulse; ignored while busy=1.
- cfg_base_addr  in  ADDR_W  first BRAM word address; sampled on accepted cfg_start.
- cfg_len  in  LEN_W  words to transfer; sampled on accepted cfg_start.
- busy  out  1  high from accepted start until done pulse inclusive.
- done  out  1  one-cycle pulse at burst completion.
- err_early_last  out  1  sticky: tlast seen before cfg_len words; cleared on next accepted start.
- err_missing_last  out  1  sticky: cfg_len-th word lacked tlast; cleared on next accepted start.
- words_written  out  LEN_W  count of acknowledged BRAM writes in current/last burst.
- ss_tvalid  in  1  stream beat valid from accelerator.
- ss_tdata  in  DATA_W  stream beat data.
- ss_tlast  in  1  last beat of packet.
- ss_tready  out  1  engine can accept beat.
- dma_w_valid  out  1  write request to arbiter.
- dma_w_addr  out  ADDR_W  BRAM word address.
- dma_w_data  out  DATA_W  write data.
- dma_w_ack  in  1  arbiter accepted the presented write this cycle.

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; counters 0; sticky flags 0. Reset mid-burst aborts immediately: FIFO flushed, dma_w_valid low the cycle after the reset edge, no done pulse.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: on cfg_start, latch base/len, clear recv_cnt, words_written and flags, busy<=1.
  - cfg_len != 0: go RUN.
  - cfg_len == 0: go FIN; no beats accepted, no writes.
- RUN:
  - ss_tready = (state==RUN) && !fifo_full, combinational from registered state.
  - Beat accepted when ss_tvalid && ss_tready; data pushed to FIFO, recv_cnt++.
  - Accepted beat with tlast and recv_cnt+1 < len: set err_early_last, go DRAIN.
  - Accepted beat with recv_cnt+1 == len: go DRAIN; set err_missing_last if tlast=0.
  - ss_tready is low from the cycle after the final beat; beats beyond len are never accepted.
- DRAIN: ss_tready=0. When FIFO empty and no write outstanding, go FIN.
- FIN: done=1 for exactly one cycle, busy stays 1 this cycle; next state IDLE with busy=0.
- Write side (active in RUN and DRAIN):
  - dma_w_valid=1 whenever FIFO non-empty.
  - dma_w_data = FIFO head; dma_w_addr = base + words_written, wrapping modulo 2^ADDR_W (8191 -> 0).
  - addr/data stay stable while dma_w_valid=1 and dma_w_ack=0.
  - On ack: pop FIFO, words_written++. The next word may be presented the following cycle; back-to-back acks give 1 word/cycle.
  - dma_w_ack while dma_w_valid=0 is ignored.
- FIFO:
  - Simultaneous push and pop when full or empty is legal; occupancy unchanged.
  - A push is allowed only when not full (ss_tready already gates this).
  - Pop-on-ack when occupancy=1 with a same-cycle push: new word is presented next cycle.
- Latency: beat accepted at cycle N -> dma_w_valid at N+1 at the earliest (registered FIFO output). done asserts the cycle after entering FIN; FIN is entered the cycle after the final ack.
- A cfg_start while busy is dropped; configuration and flags are unchanged.

Test Plan:
- Basic burst: base=0x0100, len=4, beats 0xA0..0xA3 with tlast on the 4th, ack always high -> writes 0x0100..0x0103 in order, words_written=4, done pulse, both error flags 0.
- Backpressure: len=8, ack low for 10 cycles after the first write, tvalid continuous -> ss_tready drops after FIFO_DEPTH(+1 in flight) beats; no beat lost or duplicated; 8 writes with correct data.
- Early tlast: len=6, tlast on the 3rd beat, a 4th beat presented -> 3 writes only, 4th beat never accepted, err_early_last=1, done pulse.
- Missing tlast / wrap: base=0x1FFE, len=4, no tlast -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001; err_missing_last=1.
- len=0 -> done pulse 2 cycles after start, no dma_w_valid, ss_tready stays 0. cfg_start while busy -> ignored.
- Reset mid-burst after 2 of 5 writes -> all outputs 0 next cycle, FIFO empty; a fresh burst of len=2 then completes normally.
